// File: rtl/adrv9001_ssi_rx_deframer.sv
// Purpose: CMOS SDR single-lane SSI receive deframer; aligns to the strobe lane and assembles parallel I/Q words.
// Latency: LSB on the rx_* pins at cycle n produces adc_valid at cycle n+2 (input register plus decision register).
// Backpressure: none; one I/Q pair every DATA_WIDTH cycles, and the ADC datapath must accept every adc_valid.
//
// Ports:
//   clk, rst                 SSI-domain clock, synchronous active-high reset
//   enable                   low forces SEARCH and clears framing state (error count kept)
//   mssi_sync                multi-chip sync level; its rising edge restarts framing and clears the error count
//   rx_strobe/idata/qdata    serial lanes, one bit per cycle, MSB first, strobe marks the MSB
//   adc_data_i/q, adc_valid  assembled word pair and its one-cycle qualifier
//   locked                   framing lock status
//   strobe_err_cnt           saturating count of framing violations seen while locked
module adrv9001_ssi_rx_deframer #(
    parameter int DATA_WIDTH    = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mssi_sync,
    input  logic                     rx_strobe,
    input  logic                     rx_idata,
    input  logic                     rx_qdata,
    output logic [DATA_WIDTH-1:0]    adc_data_i,
    output logic [DATA_WIDTH-1:0]    adc_data_q,
    output logic                     adc_valid,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] strobe_err_cnt
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_WIDTH - 1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input stage: every framing decision uses these registered bits.
    logic rx_strobe_q, rx_idata_q, rx_qdata_q;
    logic sync_q, sync_prev_q;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]               good_cnt_q, good_cnt_d;
    // Only the first DATA_WIDTH-1 bits need storing; the LSB joins them on the way to the output.
    logic [DATA_WIDTH-2:0]    sh_i_q, sh_i_d;
    logic [DATA_WIDTH-2:0]    sh_q_q, sh_q_d;
    logic [DATA_WIDTH-1:0]    data_i_q, data_i_d;
    logic [DATA_WIDTH-1:0]    data_q_q, data_q_d;
    logic                     valid_q, valid_d;
    logic                     locked_q, locked_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                     sync_edge;
    logic                     at_pos0;
    logic                     at_last;
    logic [CNT_W-1:0]         bit_cnt_nxt;
    logic [3:0]               good_cnt_inc;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_inc;

    // The edge is taken on the registered sync so it lines up with the registered strobe:
    // a strobe sampled alongside the edge is swallowed by the restart.
    assign sync_edge    = sync_q & ~sync_prev_q;
    assign at_pos0      = (bit_cnt_q == '0);
    assign at_last      = (bit_cnt_q == LAST_POS);
    assign bit_cnt_nxt  = at_last ? '0 : bit_cnt_q + CNT_W'(1);
    assign good_cnt_inc = good_cnt_q + 4'd1;
    assign err_cnt_inc  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        sh_i_d     = {sh_i_q[DATA_WIDTH-3:0], rx_idata_q};
        sh_q_d     = {sh_q_q[DATA_WIDTH-3:0], rx_qdata_q};
        data_i_d   = data_i_q;
        data_q_d   = data_q_q;
        valid_d    = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (sync_edge) begin
            state_d    = ST_SEARCH;
            bit_cnt_d  = '0;
            good_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (!enable) begin
            state_d    = ST_SEARCH;
            bit_cnt_d  = '0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (rx_strobe_q) begin
                        state_d    = ST_LOCKING;
                        bit_cnt_d  = CNT_W'(1);
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKING: begin
                    if (at_pos0) begin
                        if (rx_strobe_q) begin
                            bit_cnt_d  = CNT_W'(1);
                            good_cnt_d = good_cnt_inc;
                            if (good_cnt_inc == LOCK_TGT) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            state_d    = ST_SEARCH;
                            bit_cnt_d  = '0;
                            good_cnt_d = '0;
                        end
                    end else if (rx_strobe_q) begin
                        // Misplaced strobe while acquiring: restart the count from it.
                        bit_cnt_d  = CNT_W'(1);
                        good_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_nxt;
                    end
                end
                ST_LOCKED: begin
                    if (rx_strobe_q != at_pos0) begin
                        // Violation: drop the partial word; the offending strobe is not reused.
                        state_d    = ST_SEARCH;
                        bit_cnt_d  = '0;
                        good_cnt_d = '0;
                        err_cnt_d  = err_cnt_inc;
                    end else begin
                        bit_cnt_d = bit_cnt_nxt;
                        if (at_last) begin
                            data_i_d = {sh_i_q, rx_idata_q};
                            data_q_d = {sh_q_q, rx_qdata_q};
                            valid_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    bit_cnt_d  = '0;
                    good_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_strobe_q <= 1'b0;
            rx_idata_q  <= 1'b0;
            rx_qdata_q  <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            state_q     <= ST_SEARCH;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            sh_i_q      <= '0;
            sh_q_q      <= '0;
            data_i_q    <= '0;
            data_q_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rx_strobe_q <= rx_strobe;
            rx_idata_q  <= rx_idata;
            rx_qdata_q  <= rx_qdata;
            sync_q      <= mssi_sync;
            sync_prev_q <= sync_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            good_cnt_q  <= good_cnt_d;
            sh_i_q      <= sh_i_d;
            sh_q_q      <= sh_q_d;
            data_i_q    <= data_i_d;
            data_q_q    <= data_q_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign adc_data_i     = data_i_q;
    assign adc_data_q     = data_q_q;
    assign adc_valid      = valid_q;
    assign locked         = locked_q;
    assign strobe_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_adrv9001_ssi_rx_deframer.sv
// Purpose: directed self-checking bench for the SSI RX deframer at 16-bit and 8-bit word widths.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge, valid words logged with cycle stamps.
// Backpressure: none; the stimulus streams one serial bit per lane per cycle.
module tb_adrv9001_ssi_rx_deframer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mssi_sync;
    logic        rx_strobe;
    logic        rx_idata;
    logic        rx_qdata;
    logic [15:0] d16_i, d16_q;
    logic        v16, l16;
    logic [7:0]  e16;
    logic [7:0]  d8_i, d8_q;
    logic        v8, l8;
    logic [7:0]  e8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int drv_cyc;

    int          q16_cyc[$];
    logic [15:0] q16_i[$];
    logic [15:0] q16_q[$];
    int          q8_cyc[$];
    logic [7:0]  q8_i[$];
    logic [7:0]  q8_q[$];

    adrv9001_ssi_rx_deframer #(.DATA_WIDTH(16), .LOCK_COUNT(4), .ERR_CNT_WIDTH(8)) dut16 (
        .clk(clk), .rst(rst), .enable(enable), .mssi_sync(mssi_sync),
        .rx_strobe(rx_strobe), .rx_idata(rx_idata), .rx_qdata(rx_qdata),
        .adc_data_i(d16_i), .adc_data_q(d16_q), .adc_valid(v16),
        .locked(l16), .strobe_err_cnt(e16)
    );

    adrv9001_ssi_rx_deframer #(.DATA_WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .mssi_sync(mssi_sync),
        .rx_strobe(rx_strobe), .rx_idata(rx_idata), .rx_qdata(rx_qdata),
        .adc_data_i(d8_i), .adc_data_q(d8_q), .adc_valid(v8),
        .locked(l8), .strobe_err_cnt(e8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v16 === 1'b1) begin
            q16_cyc.push_back(cyc);
            q16_i.push_back(d16_i);
            q16_q.push_back(d16_q);
        end
        if (v8 === 1'b1) begin
            q8_cyc.push_back(cyc);
            q8_i.push_back(d8_i);
            q8_q.push_back(d8_q);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input logic s, input logic i, input logic q, input logic sy);
        @(negedge clk);
        rx_strobe = s;
        rx_idata  = i;
        rx_qdata  = q;
        mssi_sync = sy;
        drv_cyc   = cyc;
    endtask

    // spos: bit position carrying the strobe; -1 sends no strobe.
    task automatic send_word16(input logic [15:0] wi, input logic [15:0] wq, input int spos);
        for (int b = 0; b < 16; b++) tick(b == spos, wi[15-b], wq[15-b], 1'b0);
    endtask

    task automatic send_word8(input logic [7:0] wi, input logic [7:0] wq, input int spos);
        for (int b = 0; b < 8; b++) tick(b == spos, wi[7-b], wq[7-b], 1'b0);
    endtask

    // One more bit so the final LSB is processed, then enable low to park in SEARCH without an error.
    task automatic flush();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic clear_q();
        q16_cyc.delete(); q16_i.delete(); q16_q.delete();
        q8_cyc.delete();  q8_i.delete();  q8_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; mssi_sync = 1'b0;
        rx_strobe = 1'b0; rx_idata = 1'b0; rx_qdata = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({d16_i, d16_q, v16, l16, e16} !== 43'd0) begin
            errors++; $display("FAIL reset16 got %h want 0", {d16_i, d16_q, v16, l16, e16});
        end
        checks++;
        if ({d8_i, d8_q, v8, l8, e8} !== 27'd0) begin
            errors++; $display("FAIL reset8 got %h want 0", {d8_i, d8_q, v8, l8, e8});
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        logic [15:0] wi = 16'hA5C3;
        logic [15:0] wq = 16'h3C5A;
        int lsb5;
        clear_q();
        for (int w = 1; w <= 4; w++) send_word16(wi, wq, 0);
        tick(1'b1, wi[15], wq[15], 1'b0);
        tick(1'b0, wi[14], wq[14], 1'b0);
        checks++;
        if (l16 !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", l16); end
        tick(1'b0, wi[13], wq[13], 1'b0);
        checks++;
        if (l16 !== 1'b1) begin errors++; $display("FAIL lock_rise got %b want 1", l16); end
        for (int b = 3; b < 16; b++) tick(1'b0, wi[15-b], wq[15-b], 1'b0);
        lsb5 = drv_cyc;
        for (int w = 6; w <= 8; w++) send_word16(wi, wq, 0);
        flush();
        checks++;
        if (q16_i.size() != 4) begin errors++; $display("FAIL lock_count got %0d want 4", q16_i.size()); end
        if (q16_i.size() > 0) begin
            checks++;
            if (q16_cyc[0] != lsb5 + 2) begin
                errors++; $display("FAIL lock_latency got %0d want %0d", q16_cyc[0], lsb5 + 2);
            end
        end
        for (int k = 0; k < q16_i.size(); k++) begin
            checks++;
            if (q16_i[k] !== wi || q16_q[k] !== wq) begin
                errors++; $display("FAIL lock_data[%0d] got %h/%h want %h/%h", k, q16_i[k], q16_q[k], wi, wq);
            end
            if (k > 0) begin
                checks++;
                if (q16_cyc[k] - q16_cyc[k-1] != 16) begin
                    errors++; $display("FAIL lock_spacing[%0d] got %0d want 16", k, q16_cyc[k] - q16_cyc[k-1]);
                end
            end
        end
        checks++;
        if (e16 !== 8'd0) begin errors++; $display("FAIL lock_err got %0d want 0", e16); end
    endtask

    task automatic test_late_strobe();
        int exp_w[4] = '{5, 6, 12, 13};
        logic [15:0] ev;
        clear_q();
        for (int w = 1; w <= 13; w++) begin
            send_word16(16'h0100 + 16'(w), ~(16'h0100 + 16'(w)), (w == 7) ? 1 : 0);
            if (w == 7) begin
                checks++;
                if (l16 !== 1'b0 || e16 !== 8'd1) begin
                    errors++; $display("FAIL late_err got locked=%b err=%0d want 0/1", l16, e16);
                end
            end
        end
        flush();
        checks++;
        if (q16_i.size() != 4) begin errors++; $display("FAIL late_count got %0d want 4", q16_i.size()); end
        for (int k = 0; k < 4 && k < q16_i.size(); k++) begin
            ev = 16'h0100 + 16'(exp_w[k]);
            checks++;
            if (q16_i[k] !== ev || q16_q[k] !== ~ev) begin
                errors++; $display("FAIL late_data[%0d] got %h/%h want %h/%h", k, q16_i[k], q16_q[k], ev, ~ev);
            end
        end
    endtask

    task automatic test_missing_strobe();
        int exp_w[7] = '{5, 6, 12, 13, 14, 15, 16};
        logic [15:0] ev;
        clear_q();
        for (int w = 1; w <= 16; w++) begin
            send_word16(16'(w), ~16'(w), (w == 7) ? -1 : 0);
            if (w == 7) begin
                checks++;
                if (l16 !== 1'b0 || e16 !== 8'd2) begin
                    errors++; $display("FAIL miss_err got locked=%b err=%0d want 0/2", l16, e16);
                end
            end
        end
        flush();
        checks++;
        if (q16_i.size() != 7) begin errors++; $display("FAIL miss_count got %0d want 7", q16_i.size()); end
        for (int k = 0; k < 7 && k < q16_i.size(); k++) begin
            ev = 16'(exp_w[k]);
            checks++;
            if (q16_i[k] !== ev || q16_q[k] !== ~ev) begin
                errors++; $display("FAIL miss_data[%0d] got %h/%h want %h/%h", k, q16_i[k], q16_q[k], ev, ~ev);
            end
        end
    endtask

    task automatic test_err_saturation();
        clear_q();
        for (int it = 1; it <= 300; it++) begin
            for (int w = 1; w <= 5; w++) send_word16(16'hA5C3, 16'h3C5A, 0);
            send_word16(16'hA5C3, 16'h3C5A, -1);
            if (it == 252) begin
                checks++;
                if (e16 !== 8'd254) begin errors++; $display("FAIL sat_mid got %0d want 254", e16); end
            end
        end
        checks++;
        if (e16 !== 8'hFF) begin errors++; $display("FAIL sat_full got %h want ff", e16); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (e16 !== 8'h00) begin errors++; $display("FAIL sat_sync_clear got %h want 00", e16); end
    endtask

    task automatic test_mssi_sync();
        int exp_w[4] = '{5, 11, 12, 13};
        logic [15:0] wi, ev;
        clear_q();
        for (int w = 1; w <= 5; w++) send_word16(16'h0200 + 16'(w), ~(16'h0200 + 16'(w)), 0);
        wi = 16'h0206;
        for (int b = 0; b < 14; b++) tick(b == 0, wi[15-b], ~wi[15-b], 1'b0);
        tick(1'b0, wi[1], ~wi[1], 1'b1);
        tick(1'b0, wi[0], ~wi[0], 1'b1);
        checks++;
        if (l16 !== 1'b1) begin errors++; $display("FAIL sync_hold got %b want 1", l16); end
        wi = 16'h0207;
        tick(1'b1, wi[15], ~wi[15], 1'b1);
        checks++;
        if (l16 !== 1'b0) begin errors++; $display("FAIL sync_unlock got %b want 0", l16); end
        for (int b = 1; b < 16; b++) tick(1'b0, wi[15-b], ~wi[15-b], 1'b0);
        for (int w = 8; w <= 13; w++) send_word16(16'h0200 + 16'(w), ~(16'h0200 + 16'(w)), 0);
        flush();
        checks++;
        if (q16_i.size() != 4) begin errors++; $display("FAIL sync_count got %0d want 4", q16_i.size()); end
        for (int k = 0; k < 4 && k < q16_i.size(); k++) begin
            ev = 16'h0200 + 16'(exp_w[k]);
            checks++;
            if (q16_i[k] !== ev || q16_q[k] !== ~ev) begin
                errors++; $display("FAIL sync_data[%0d] got %h/%h want %h/%h", k, q16_i[k], q16_q[k], ev, ~ev);
            end
        end
        checks++;
        if (e16 !== 8'd0) begin errors++; $display("FAIL sync_err got %0d want 0", e16); end
    endtask

    task automatic test_width8_reset();
        logic [7:0] wi = 8'h5A;
        logic [7:0] wq = 8'hC3;
        int lsb5;
        @(negedge clk); rst = 1'b1;
        rx_strobe = 1'b0; rx_idata = 1'b0; rx_qdata = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
        for (int w = 1; w <= 11; w++) send_word8(wi, wq, (w == 6) ? -1 : 0);
        for (int b = 0; b < 3; b++) tick(b == 0, wi[7-b], wq[7-b], 1'b0);
        checks++;
        if (l8 !== 1'b1 || e8 !== 8'd1) begin
            errors++; $display("FAIL w8_pre got locked=%b err=%0d want 1/1", l8, e8);
        end
        checks++;
        if (q8_i.size() != 2) begin errors++; $display("FAIL w8_pre_count got %0d want 2", q8_i.size()); end
        @(negedge clk); rst = 1'b1;
        rx_strobe = 1'b0; rx_idata = 1'b0; rx_qdata = 1'b0;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({d8_i, d8_q, v8, l8, e8} !== 27'd0) begin
            errors++; $display("FAIL w8_reset got %h want 0", {d8_i, d8_q, v8, l8, e8});
        end
        clear_q();
        lsb5 = 0;
        for (int w = 1; w <= 7; w++) begin
            send_word8(wi, wq, 0);
            if (w == 5) lsb5 = drv_cyc;
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (q8_i.size() != 3) begin errors++; $display("FAIL w8_count got %0d want 3", q8_i.size()); end
        if (q8_i.size() > 0) begin
            checks++;
            if (q8_cyc[0] != lsb5 + 2) begin
                errors++; $display("FAIL w8_latency got %0d want %0d", q8_cyc[0], lsb5 + 2);
            end
        end
        for (int k = 0; k < q8_i.size(); k++) begin
            checks++;
            if (q8_i[k] !== wi || q8_q[k] !== wq) begin
                errors++; $display("FAIL w8_data[%0d] got %h/%h want %h/%h", k, q8_i[k], q8_q[k], wi, wq);
            end
            if (k > 0) begin
                checks++;
                if (q8_cyc[k] - q8_cyc[k-1] != 8) begin
                    errors++; $display("FAIL w8_spacing[%0d] got %0d want 8", k, q8_cyc[k] - q8_cyc[k-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_late_strobe();
        test_missing_strobe();
        test_err_saturation();
        test_mssi_sync();
        test_width8_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
